// File: rtl/wavegen_mem_pkg.sv
// Shared constants for the waveform/instruction memory read path.
// Requester slot 0 is the CPU fetch and slot 1 the segment fetch.
package wavegen_mem_pkg;
  localparam int ADDR_W  = 33;
  localparam int DATA_W  = 128;
  localparam int REQ_CPU = 0;
  localparam int REQ_SEG = 1;
endpackage

// File: rtl/mem_rd_tag_fifo.sv
// Tag FIFO recording which requester owns each in-flight read.
// Push and pop may happen on the same edge.
module mem_rd_tag_fifo
  import wavegen_mem_pkg::*;
#(
  parameter int TAG_W = 1,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] pop_tag,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_tag = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Round-robin arbiter sharing the single memory read port among requesters,
// with up to MAX_OUTST in-order reads in flight routed back by tag.
module mem_rd_arbiter
  import wavegen_mem_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = wavegen_mem_pkg::ADDR_W,
  parameter int DATA_W    = wavegen_mem_pkg::DATA_W,
  parameter int MAX_OUTST = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         req_data,
  output logic                      mem_rd_valid,
  output logic [ADDR_W-1:0]         mem_rd_addr,
  input  logic                      mem_rd_ready,
  input  logic                      mem_rd_ack,
  input  logic [DATA_W-1:0]         mem_rd_data,
  output logic                      busy,
  output logic                      err_unexp_ack
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  typedef struct packed {
    logic             found;
    logic [TAG_W-1:0] idx;
  } pick_t;

  // First eligible requester after last, wrapping around.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] elig,
                                    input logic [TAG_W-1:0]   last);
    pick_t            p;
    logic [TAG_W-1:0] jj;
    p = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      jj = TAG_W'((int'(last) + k) % NUM_REQ);
      if (elig[jj]) begin
        p.found = 1'b1;
        p.idx   = jj;
      end
    end
    return p;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [TAG_W-1:0] t);
    return NUM_REQ'(1) << t;
  endfunction

  logic                rd_valid_p0;
  logic [ADDR_W-1:0]   rd_addr_p0;
  logic [TAG_W-1:0]    rd_idx_p0;
  logic [TAG_W-1:0]    last_grant;
  logic [NUM_REQ-1:0]  outst;
  logic [NUM_REQ-1:0]  ack_p1;
  logic [DATA_W-1:0]   data_p1;
  logic                err_q;
  logic [NUM_REQ-1:0]  elig;
  pick_t               pick;
  logic                hs;
  logic                pop;
  logic                load;
  logic [TAG_W-1:0]    head_tag;
  logic                fifo_empty;
  logic [CNT_W-1:0]    count;

  mem_rd_tag_fifo #(
    .TAG_W (TAG_W),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (hs),
    .push_tag (rd_idx_p0),
    .pop      (pop),
    .pop_tag  (head_tag),
    .empty    (fifo_empty),
    .count    (count)
  );

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req_valid[i] & ~outst[i] & ~(rd_valid_p0 && (rd_idx_p0 == TAG_W'(i)));
  end

  assign pick = rr_pick(elig, last_grant);
  assign hs   = rd_valid_p0 & mem_rd_ready;
  assign pop  = mem_rd_ack & ~fifo_empty;
  // A slot pushed this cycle is already taken; a pop only frees it next edge.
  assign load = (~rd_valid_p0 | hs) & pick.found &
                ((int'(count) + int'(hs)) < MAX_OUTST);

  // Stage p0: registered address channel and grant bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_p0 <= 1'b0;
      rd_addr_p0  <= '0;
      rd_idx_p0   <= '0;
      last_grant  <= TAG_W'(NUM_REQ - 1);
      outst       <= '0;
    end else begin
      if (load) begin
        rd_valid_p0 <= 1'b1;
        rd_addr_p0  <= req_addr[pick.idx*ADDR_W +: ADDR_W];
        rd_idx_p0   <= pick.idx;
        last_grant  <= pick.idx;
      end else if (hs) begin
        rd_valid_p0 <= 1'b0;
      end
      outst <= (outst & ~ack_p1) | (hs ? onehot(rd_idx_p0) : '0);
    end
  end

  // Stage p1: response routing back to the owning requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_p1  <= '0;
      data_p1 <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_p1 <= pop ? onehot(head_tag) : '0;
      if (pop) data_p1 <= mem_rd_data;
      if (mem_rd_ack && fifo_empty) err_q <= 1'b1;
    end
  end

  assign mem_rd_valid  = rd_valid_p0;
  assign mem_rd_addr   = rd_addr_p0;
  assign req_ack       = ack_p1;
  assign req_data      = data_p1;
  assign err_unexp_ack = err_q;
  assign busy          = (|req_valid) | rd_valid_p0 | (|outst);

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Cycle-based bench: requester and memory models drive the arbiter, a
// scoreboard of expected responses is filled as the memory model answers.
`timescale 1ns/1ps
module tb_mem_rd_arbiter;
  import wavegen_mem_pkg::*;

  localparam int NREQ = 2;
  localparam logic [DATA_W-1:0] BASE = 128'hA000_0000_0000_0000_0000_0D00_0000_0011;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic                   mem_rd_ready = 1'b0;
  logic                   mem_rd_ack = 1'b0;
  logic [DATA_W-1:0]      mem_rd_data = '0;

  logic [NREQ-1:0]   ack0, ack1;
  logic [DATA_W-1:0] data0, data1;
  logic              v0, v1, b0, b1, e0, e1;
  logic [ADDR_W-1:0] a0, a1;
  logic              sel = 1'b0;

  logic [NREQ-1:0]   m_ack;
  logic [DATA_W-1:0] m_data;
  logic              m_valid, m_busy, m_err;
  logic [ADDR_W-1:0] m_addr;

  assign m_ack   = sel ? ack1  : ack0;
  assign m_data  = sel ? data1 : data0;
  assign m_valid = sel ? v1    : v0;
  assign m_addr  = sel ? a1    : a0;
  assign m_busy  = sel ? b1    : b0;
  assign m_err   = sel ? e1    : e0;

  mem_rd_arbiter #(.NUM_REQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ack(ack0), .req_data(data0), .mem_rd_valid(v0), .mem_rd_addr(a0),
    .mem_rd_ready(mem_rd_ready), .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .busy(b0), .err_unexp_ack(e0));

  mem_rd_arbiter #(.NUM_REQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ack(ack1), .req_data(data1), .mem_rd_valid(v1), .mem_rd_addr(a1),
    .mem_rd_ready(mem_rd_ready), .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .busy(b1), .err_unexp_ack(e1));

  always #5 clk = ~clk;

  typedef struct { int idx; logic [ADDR_W-1:0] addr; int due; } rd_t;
  typedef struct { int idx; logic [DATA_W-1:0] data; } exp_t;

  rd_t               mq[$];
  exp_t              sq[$];
  int                log_idx[$];
  int                log_cyc[$];
  logic [ADDR_W-1:0] log_addr[$];
  int                ack_cyc_log[$];

  int                nchk = 0;
  int                nerr = 0;
  int                cyc = 0;
  int                mem_lat = 3;
  bit                ready_ok = 1'b0;
  bit                inject = 1'b0;
  bit                ack_due = 1'b0;
  bit                prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  bit                rq_on[NREQ];
  logic [ADDR_W-1:0] rq_addr[NREQ];
  int                rq_left[NREQ];

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  function automatic logic [DATA_W-1:0] fdata(input logic [ADDR_W-1:0] a);
    return BASE ^ (DATA_W'(a) << 64) ^ DATA_W'(a);
  endfunction

  task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input int n);
    rq_on[i]   = 1'b1;
    rq_addr[i] = a;
    rq_left[i] = n;
  endtask

  task automatic clear_logs();
    log_idx.delete();
    log_cyc.delete();
    log_addr.delete();
    ack_cyc_log.delete();
  endtask

  task automatic cycle();
    exp_t e;
    rd_t  r;
    int   hit;
    @(posedge clk);
    #1;
    cyc++;
    if (ack_due || m_ack != '0) begin
      if (sq.size() == 0) begin
        chk("ack_extra", DATA_W'(m_ack), '0);
      end else begin
        e = sq.pop_front();
        if (e.idx < 0) begin
          chk("ack_none", DATA_W'(m_ack), '0);
          chk("err_set", DATA_W'(m_err), 1);
        end else begin
          chk("ack_vec", DATA_W'(m_ack), DATA_W'(oh(e.idx)));
          chk("ack_data", m_data, e.data);
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (m_ack[i] && rq_on[i]) begin
        rq_left[i]--;
        if (rq_left[i] > 0) rq_addr[i] = rq_addr[i] + ADDR_W'(16);
        else rq_on[i] = 1'b0;
      end
      req_valid[i] = rq_on[i];
      req_addr[i*ADDR_W +: ADDR_W] = rq_addr[i];
    end
    mem_rd_ready = ready_ok;
    ack_due      = 1'b0;
    mem_rd_ack   = 1'b0;
    if (inject) begin
      inject      = 1'b0;
      mem_rd_ack  = 1'b1;
      mem_rd_data = {4{$urandom}};
      sq.push_back('{-1, '0});
      ack_due     = 1'b1;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      r           = mq.pop_front();
      mem_rd_ack  = 1'b1;
      mem_rd_data = fdata(r.addr);
      sq.push_back('{r.idx, fdata(r.addr)});
      ack_due     = 1'b1;
      if (r.idx >= 0) ack_cyc_log.push_back(cyc);
    end
    #1;
    if (prev_stall) begin
      chk("stall_valid", DATA_W'(m_valid), 1);
      chk("stall_addr", DATA_W'(m_addr), DATA_W'(prev_addr));
    end
    prev_stall = m_valid & ~mem_rd_ready;
    prev_addr  = m_addr;
    if (m_valid && mem_rd_ready) begin
      hit = -1;
      for (int i = 0; i < NREQ; i++)
        if (rq_on[i] && rq_addr[i] == m_addr) hit = i;
      chk("hs_owner_known", DATA_W'(hit >= 0), 1);
      mq.push_back('{hit, m_addr, cyc + mem_lat});
      log_idx.push_back(hit);
      log_cyc.push_back(cyc);
      log_addr.push_back(m_addr);
    end
  endtask

  task automatic apply_reset(input bit check_vals);
    rst_n      = 1'b0;
    mem_rd_ack = 1'b0;
    for (int i = 0; i < NREQ; i++) rq_on[i] = 1'b0;
    req_valid = '0;
    #1;
    if (check_vals) begin
      chk("rst_valid", DATA_W'(m_valid), 0);
      chk("rst_addr", DATA_W'(m_addr), 0);
      chk("rst_ack", DATA_W'(m_ack), 0);
      chk("rst_data", m_data, 0);
      chk("rst_busy", DATA_W'(m_busy), 0);
      chk("rst_err", DATA_W'(m_err), 0);
    end
    // reads already issued still complete at the memory; their acks are stale
    foreach (mq[k]) mq[k].idx = -1;
    sq.delete();
    ack_due    = 1'b0;
    prev_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      cycle();
      done = (mq.size() == 0) && (sq.size() == 0) && !m_valid && (m_ack == '0);
      for (int i = 0; i < NREQ; i++) if (rq_on[i]) done = 1'b0;
    end
    chk("idle_reached", DATA_W'(done), 1);
    chk("idle_busy", DATA_W'(m_busy), 0);
  endtask

  initial begin
    int t0;
    int tr;
    for (int i = 0; i < NREQ; i++) begin
      rq_on[i] = 1'b0; rq_addr[i] = '0; rq_left[i] = 0;
    end
    rst_n = 1'b1;
    #2;
    apply_reset(1'b1);

    // Single CPU read
    ready_ok = 1'b1;
    clear_logs();
    set_req(REQ_CPU, '0, 1);
    t0 = cyc + 1;
    cycle();
    chk("t1_busy", DATA_W'(m_busy), 1);
    wait_idle(40);
    chk("t1_ngrant", DATA_W'(log_idx.size()), 1);
    chk("t1_addr", DATA_W'(log_addr[0]), 0);
    chk("t1_lat", DATA_W'(log_cyc[0]), DATA_W'(t0 + 1));

    // Contention
    apply_reset(1'b0);
    clear_logs();
    set_req(REQ_CPU, 33'h100, 1);
    set_req(REQ_SEG, 33'h200, 1);
    t0 = cyc + 1;
    wait_idle(40);
    chk("t2_ngrant", DATA_W'(log_idx.size()), 2);
    chk("t2_idx0", DATA_W'(log_idx[0]), 0);
    chk("t2_addr0", DATA_W'(log_addr[0]), 'h100);
    chk("t2_cyc0", DATA_W'(log_cyc[0]), DATA_W'(t0 + 1));
    chk("t2_idx1", DATA_W'(log_idx[1]), 1);
    chk("t2_addr1", DATA_W'(log_addr[1]), 'h200);
    chk("t2_cyc1", DATA_W'(log_cyc[1]), DATA_W'(t0 + 2));

    // Fairness
    apply_reset(1'b0);
    clear_logs();
    set_req(REQ_CPU, 33'h100, 4);
    set_req(REQ_SEG, 33'h200, 4);
    wait_idle(120);
    chk("t3_ngrant", DATA_W'(log_idx.size()), 8);
    for (int k = 0; k < 8 && k < log_idx.size(); k++)
      chk("t3_order", DATA_W'(log_idx[k]), DATA_W'(k % 2));

    // Backpressure with a single read slot
    sel = 1'b1;
    apply_reset(1'b0);
    clear_logs();
    ready_ok = 1'b0;
    set_req(REQ_CPU, 33'h300, 1);
    set_req(REQ_SEG, 33'h400, 1);
    repeat (6) cycle();
    chk("t4_stall_valid", DATA_W'(m_valid), 1);
    chk("t4_stall_addr", DATA_W'(m_addr), 'h300);
    ready_ok = 1'b1;
    tr = cyc + 1;
    wait_idle(60);
    chk("t4_ngrant", DATA_W'(log_idx.size()), 2);
    chk("t4_first_idx", DATA_W'(log_idx[0]), 0);
    chk("t4_first_cyc", DATA_W'(log_cyc[0]), DATA_W'(tr));
    chk("t4_second_after_pop", DATA_W'(log_cyc[1]), DATA_W'(ack_cyc_log[0] + 2));

    // Unexpected ack
    sel = 1'b0;
    apply_reset(1'b0);
    inject = 1'b1;
    cycle();
    repeat (4) cycle();
    chk("t5_err_sticky", DATA_W'(m_err), 1);
    chk("t5_no_ack", DATA_W'(m_ack), 0);

    // Reset with reads in flight
    apply_reset(1'b0);
    clear_logs();
    mem_lat = 6;
    set_req(REQ_CPU, 33'h500, 1);
    set_req(REQ_SEG, 33'h600, 1);
    for (int n = 0; n < 10 && mq.size() < 2; n++) cycle();
    chk("t6_two_outst", DATA_W'(mq.size()), 2);
    apply_reset(1'b1);
    mem_lat = 3;
    repeat (10) cycle();
    chk("t6_err_after", DATA_W'(m_err), 1);
    clear_logs();
    set_req(REQ_CPU, 33'h700, 1);
    wait_idle(40);
    chk("t6_ngrant", DATA_W'(log_idx.size()), 1);
    chk("t6_addr", DATA_W'(log_addr[0]), 'h700);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
